// File: rtl/cpu_pkg.sv
// Shared CPU constants and the state type of the multi-cycle right shifter.
package cpu_pkg;

  localparam int XLEN    = 32;
  localparam int SHAMT_W = 5;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } srl_state_e;

endpackage

// File: rtl/srl_step.sv
// Combinational right shift by n positions with a configurable fill bit.
// n may range up to XLEN, so the same block serves a single-cycle variant.
module srl_step
  import cpu_pkg::*;
(
  input  logic [XLEN-1:0]  acc_i,
  input  logic             fill_i,
  input  logic [SHAMT_W:0] n_i,
  output logic [XLEN-1:0]  res_o
);

  logic [2*XLEN-1:0] ext;

  // The fill bits sit above acc and slide down into the vacated top positions.
  assign ext   = {{XLEN{fill_i}}, acc_i} >> n_i;
  assign res_o = ext[XLEN-1:0];

endmodule

// File: rtl/srl32_seq.sv
// Multi-cycle 32-bit logical/arithmetic right shifter, at most STEP bits per clock,
// with a start/busy/done handshake and synchronous flush.
module srl32_seq
  import cpu_pkg::*;
#(
  parameter int STEP  = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             flush,
  input  logic             arith,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] O,
  output logic             busy,
  output logic             done
);

  localparam logic [SHAMT_W:0] STEP_N = STEP[SHAMT_W:0];

  srl_state_e         state_q, state_d;
  logic [XLEN-1:0]    acc_q, acc_d;
  logic [SHAMT_W-1:0] rem_q, rem_d;
  logic               fill_q, fill_d;
  logic [XLEN-1:0]    o_q, o_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [SHAMT_W:0]   n;
  logic [XLEN-1:0]    acc_shifted;
  logic               unused_b_hi;

  assign unused_b_hi = ^B[WIDTH-1:SHAMT_W];

  assign n = ({1'b0, rem_q} < STEP_N) ? {1'b0, rem_q} : STEP_N;

  srl_step u_step (
    .acc_i  (acc_q),
    .fill_i (fill_q),
    .n_i    (n),
    .res_o  (acc_shifted)
  );

  // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    fill_d  = fill_q;
    o_d     = o_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start && !flush) begin
          acc_d   = A;
          rem_d   = B[SHAMT_W-1:0];
          fill_d  = arith & A[XLEN-1];
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (flush) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (rem_q == '0) begin
          o_d     = acc_q;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          acc_d = acc_shifted;
          rem_d = rem_q - n[SHAMT_W-1:0];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      rem_q   <= '0;
      fill_q  <= 1'b0;
      o_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      fill_q  <= fill_d;
      o_q     <= o_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign O    = o_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_srl32_seq.sv
// Directed self-checking bench for srl32_seq with STEP=4.
module tb_srl32_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        flush;
  logic        arith;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] O;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;
  int cycles;

  srl32_seq #(.STEP(4), .WIDTH(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .flush (flush),
    .arith (arith),
    .A     (A),
    .B     (B),
    .O     (O),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; sampling happens 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(output int n_edges);
    n_edges = 0;
    do begin
      tick();
      n_edges++;
    end while (!done && n_edges < 40);
  endtask

  task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic ar);
    A = a; B = b; arith = ar; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; flush = 1'b0; arith = 1'b0; A = '0; B = '0;
    #3;
    check("reset_O", O, 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_done", 32'(done), 32'h0);
    rst = 1'b0;

    // Test 1: logical shift by 4
    launch(32'h8000_0000, 32'd4, 1'b0);
    check("t1_busy_e0", 32'(busy), 32'h1);
    tick();
    check("t1_busy_e1", 32'(busy), 32'h1);
    check("t1_done_e1", 32'(done), 32'h0);
    tick();
    check("t1_done_e2", 32'(done), 32'h1);
    check("t1_busy_e2", 32'(busy), 32'h0);
    check("t1_O", O, 32'h0800_0000);
    tick();
    check("t1_done_pulse", 32'(done), 32'h0);
    check("t1_O_hold", O, 32'h0800_0000);

    // Test 2: maximum shift amount, arithmetic and logical
    launch(32'h8000_0000, 32'd31, 1'b1);
    wait_done(cycles);
    check("t2a_latency", 32'(cycles), 32'd9);
    check("t2a_O", O, 32'hFFFF_FFFF);
    launch(32'h8000_0000, 32'd31, 1'b0);
    wait_done(cycles);
    check("t2l_latency", 32'(cycles), 32'd9);
    check("t2l_O", O, 32'h0000_0001);

    // Test 3: upper bits of B ignored (0x25 -> shift by 5)
    launch(32'h0000_00F0, 32'h0000_0025, 1'b0);
    wait_done(cycles);
    check("t3_latency", 32'(cycles), 32'd3);
    check("t3_O", O, 32'h0000_0007);

    // Arithmetic with positive operand fills zeros
    launch(32'h7000_0000, 32'd6, 1'b1);
    wait_done(cycles);
    check("t3b_O", O, 32'h01C0_0000);

    // Test 4: zero shift
    launch(32'h1234_5678, 32'd0, 1'b1);
    wait_done(cycles);
    check("t4_latency", 32'(cycles), 32'd1);
    check("t4_O", O, 32'h1234_5678);

    // Test 5: start while busy ignored, start in done cycle accepted
    launch(32'hFFFF_0000, 32'd16, 1'b0);
    tick();
    A = 32'h1; B = 32'd0; start = 1'b1;
    tick();
    start = 1'b0;
    check("t5_busy_after_restart", 32'(busy), 32'h1);
    wait_done(cycles);
    check("t5_latency_rest", 32'(cycles), 32'd3);
    check("t5_O", O, 32'h0000_FFFF);
    launch(32'h0000_00F0, 32'd4, 1'b0);
    check("t5_b2b_busy", 32'(busy), 32'h1);
    wait_done(cycles);
    check("t5_b2b_latency", 32'(cycles), 32'd2);
    check("t5_b2b_O", O, 32'h0000_000F);

    // Test 6a: flush mid-shift
    launch(32'hDEAD_BEEF, 32'd20, 1'b1);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t6_flush_busy", 32'(busy), 32'h0);
    check("t6_flush_done", 32'(done), 32'h0);
    repeat (6) tick();
    check("t6_flush_no_done", 32'(done), 32'h0);
    check("t6_flush_O_hold", O, 32'h0000_000F);

    // flush together with start while idle: start ignored
    A = 32'h5555_5555; B = 32'd0; start = 1'b1; flush = 1'b1;
    tick();
    start = 1'b0; flush = 1'b0;
    check("t6_flush_start_busy", 32'(busy), 32'h0);

    // flush on the completion edge wins
    launch(32'hAAAA_AAAA, 32'd0, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t6_flush_cmpl_done", 32'(done), 32'h0);
    check("t6_flush_cmpl_O", O, 32'h0000_000F);
    check("t6_flush_cmpl_busy", 32'(busy), 32'h0);

    // Test 6b: asynchronous reset mid-shift
    launch(32'hCAFE_F00D, 32'd31, 1'b1);
    tick();
    check("t6_pre_rst_busy", 32'(busy), 32'h1);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_O", O, 32'h0);
    check("t6_rst_busy", 32'(busy), 32'h0);
    check("t6_rst_done", 32'(done), 32'h0);
    rst = 1'b0;

    // Recovery after reset
    launch(32'hF000_0000, 32'd8, 1'b1);
    wait_done(cycles);
    check("post_rst_latency", 32'(cycles), 32'd3);
    check("post_rst_O", O, 32'hFFF0_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
